alu_share_ctrl: RTL and testbench

Time-shares the single 32-bit ALU between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each port uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, latches operands, drives the external ALU for one cycle, and registers the result, the zero flag and an illegal-opcode flag. The ALU stays a separate instance, wired through the alu_* ports.

---
 rtl/alu_share_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Time-shares one external ALU between two requesters
//            (port 0 = execute stage, port 1 = branch/address unit).
//            Round-robin arbitration, operand latching, one-cycle ALU
//            drive and registered result / zero / illegal-opcode flags.
// Ports    : clk, rst_n                   clock, async active-low reset
//            reqN_valid/ready/a/b/op      request channel per port (N=0,1)
//            rspN_valid/ready             response channel per port
//            rsp_result/zero/err          shared registered response data
//            alu_a/b/ctrl -> ALU,  alu_result/zero <- ALU
// Revision : 1.0  initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [OPW-1:0] c_op_add = OPW'(4'b0000);
  localparam logic [OPW-1:0] c_op_sub = OPW'(4'b0001);
  localparam logic [OPW-1:0] c_op_and = OPW'(4'b0010);
  localparam logic [OPW-1:0] c_op_or  = OPW'(4'b0100);
  localparam logic [OPW-1:0] c_op_sll = OPW'(4'b1000);
  localparam logic [OPW-1:0] c_op_srl = OPW'(4'b0011);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;  // port served by the most recent handshake
  logic             r_owner;       // port owning the transaction in flight
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic             w_any;
  logic             w_grant;
  logic             w_accept;
  logic             w_legal;

  // On a tie the port not served last wins; otherwise the lone requester.
  assign w_any    = req0_valid | req1_valid;
  assign w_grant  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept = (r_state == S_IDLE) && w_any;

  assign w_legal = (r_op == c_op_add) || (r_op == c_op_sub) ||
                   (r_op == c_op_and) || (r_op == c_op_or)  ||
                   (r_op == c_op_sll) || (r_op == c_op_srl);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Readies are combinational from the valids, so hold them low while
        // reset is asserted to keep the outputs at their reset values.
        if (rst_n && w_any) begin
          req0_ready = ~w_grant;
          req1_ready = w_grant;
          w_next     = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~r_owner;
        rsp1_valid = r_owner;
        if (r_owner ? rsp1_ready : rsp0_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant ? req1_a  : req0_a;
        r_b          <= w_grant ? req1_b  : req0_b;
        r_op         <= w_grant ? req1_op : req0_op;
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == S_EXEC) begin
        // An illegal code leaves the ALU output undefined, so never sample it.
        if (w_legal) begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_err    <= 1'b0;
        end else begin
          r_result <= '0;
          r_zero   <= 1'b0;
          r_err    <= 1'b1;
        end
      end
    end
  end

  // The ALU inputs simply follow the operand latch, which holds between ops.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_op;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Scoreboard bench for alu_share_ctrl with a behavioural ALU.
//            Stimulus pushes hand-computed expectations on acceptance; a
//            monitor pops and compares on each retired response.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_zero, rsp_err, alu_zero;
  logic [3:0]  alu_ctrl;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_share_ctrl #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural ALU. Illegal codes return a poison pattern standing in for an
  // undriven bus, so a controller that samples it is caught.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    alu_zero   = 1'b1;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      4'b1000: alu_result = alu_a << alu_b;
      4'b0011: alu_result = alu_a >> alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    if (alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011})
      alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: compares every retired response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: actual valids=%b required=none", {rsp1_valid, rsp0_valid});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_port",   {30'd0, rsp1_valid, rsp0_valid}, e.port ? 32'd2 : 32'd1);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
        chk("rsp_err",    {31'd0, rsp_err},  {31'd0, e.err});
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk({tag, "_rsp_flags"}, {rsp_result[29:0], rsp_zero, rsp_err}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b_ctrl"}, alu_b | {28'd0, alu_ctrl}, 32'd0);
  endtask

  task automatic set_req(input logic port, input logic [31:0] a, b, input logic [3:0] op);
    if (port) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
  endtask

  // Issue one request, push its expectation on acceptance, check latency.
  task automatic send(input logic port, input logic [31:0] a, b, input logic [3:0] op,
                      input logic [31:0] er, input logic ez, input logic ee);
    int n = 0;
    bit got = 0;
    set_req(port, a, b, op);
    while (!got && n < 20) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) got = 1;
      n++;
    end
    chk("accept", {31'd0, got}, 32'd1);
    if (got) sb.push_back('{port, er, ez, ee});
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!got) return;
    @(negedge clk);
    chk("exec_rsp_quiet", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, op});
    @(negedge clk);
    chk("latency_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input logic port, input string tag);
    int n = 0;
    bit got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) got = 1;
      n++;
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] gseq;
    int         ng;
    int         n;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op; port 1 must stay silent
    send(0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b0);
    drain("drain_single");

    // Zero flag and wrap-around, both on port 1
    send(1, 32'h1234, 32'h1234, 4'b0001, 32'd0, 1'b1, 1'b0);
    send(1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 1'b1, 1'b0);
    drain("drain_zero");

    // Round-robin with both ports continuously valid
    gseq = 4'b0000; ng = 0; n = 0;
    set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 4'b0100);
    while (ng < 4 && n < 40) begin
      @(negedge clk);
      if (req0_ready) begin
        sb.push_back('{1'b0, 32'hF000_F000, 1'b0, 1'b0}); gseq[ng] = 1'b0; ng++;
      end else if (req1_ready) begin
        sb.push_back('{1'b1, 32'h0000_00FF, 1'b0, 1'b0}); gseq[ng] = 1'b1; ng++;
      end
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", ng, 32'd4);
    chk("rr_order", {28'd0, gseq}, 32'b1010);
    drain("drain_rr");

    // Backpressure on port 0 with port 1 waiting
    rsp0_ready = 0;
    set_req(0, 32'd10, 32'd3, 4'b0001);
    set_req(1, 32'd1, 32'd2, 4'b0000);
    wait_ready(0, "bp_accept0");
    chk("bp_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
    sb.push_back('{1'b0, 32'd7, 1'b0, 1'b0});
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_result", rsp_result, 32'd7);
      chk("bp_hold_valid_noready", {30'd0, rsp0_valid, req1_ready}, 32'd2);
    end
    @(posedge clk); #1; rsp0_ready = 1;
    @(negedge clk);
    chk("bp_retire_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    chk("bp_after_req1_ready", {31'd0, req1_ready}, 32'd1);
    sb.push_back('{1'b1, 32'd3, 1'b0, 1'b0});
    @(posedge clk); #1; req1_valid = 0;
    drain("drain_bp");

    // Illegal opcode, then a legal shift
    send(0, 32'h55, 32'h66, 4'b0111, 32'd0, 1'b0, 1'b1);
    send(0, 32'd1, 32'd4, 4'b1000, 32'd16, 1'b0, 1'b0);
    drain("drain_illegal");

    // Reset during EXEC; port 0 was served last, so a stale last_grant
    // would hand the next tie to port 1.
    set_req(0, 32'd3, 32'd4, 4'b0000);
    wait_ready(0, "rst_accept");
    @(posedge clk); #1; req0_valid = 0;
    #2;
    rst_n = 1'b0;
    set_req(0, 32'd2, 32'd2, 4'b0000);
    set_req(1, 32'd8, 32'd1, 4'b0100);
    #1;
    check_reset("midop");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    chk("post_rst_no_stale", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    sb.push_back('{1'b0, 32'd4, 1'b0, 1'b0});
    @(posedge clk); #1; req0_valid = 0;
    wait_ready(1, "post_rst_accept1");
    sb.push_back('{1'b1, 32'd9, 1'b0, 1'b0});
    @(posedge clk); #1; req1_valid = 0;
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
